// File: rtl/term_pkg.sv
// Shared constants for the terminal line decoder: opcode bit indices, ASCII codes,
// FSM state encoding and the command table lookup.
package term_pkg;

  localparam int LINE_LEN = 5;
  localparam int OP_W     = 11;
  localparam int DISP_W   = 8 * LINE_LEN;

  localparam int OP_CLR  = 0;
  localparam int OP_ADD  = 1;
  localparam int OP_SUB  = 2;
  localparam int OP_MUL  = 3;
  localparam int OP_AND  = 4;
  localparam int OP_OR   = 5;
  localparam int OP_XOR  = 6;
  localparam int OP_NOT  = 7;
  localparam int OP_RXN  = 8;
  localparam int OP_LED  = 9;
  localparam int OP_HELP = 10;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_MATCH,
    ST_EMIT
  } state_t;

  // Space-padded command word for a given opcode bit. Unused indices return zero,
  // which no buffer content can ever equal (slots only hold 0x20..0x7E).
  function automatic logic [DISP_W-1:0] cmd_word(input int idx);
    case (idx)
      OP_CLR:  return "CLR  ";
      OP_ADD:  return "ADD  ";
      OP_SUB:  return "SUB  ";
      OP_MUL:  return "MUL  ";
      OP_AND:  return "AND  ";
      OP_OR:   return "OR   ";
      OP_XOR:  return "XOR  ";
      OP_NOT:  return "NOT  ";
      OP_RXN:  return "RXN  ";
      OP_LED:  return "LED  ";
      OP_HELP: return "HELP ";
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/term_cmd_decoder_if.sv
// Keystroke input handshake plus decoded-command outputs of the line decoder.
interface term_cmd_decoder_if;
  import term_pkg::*;

  logic [7:0]        key_ascii;
  logic              key_valid;
  logic              key_ready;
  logic [OP_W-1:0]   op_code;
  logic              op_strobe;
  logic              cmd_err;
  logic [DISP_W-1:0] display;

  modport master (
    output key_ascii, key_valid,
    input  key_ready, op_code, op_strobe, cmd_err, display
  );

  modport slave (
    input  key_ascii, key_valid,
    output key_ready, op_code, op_strobe, cmd_err, display
  );

endinterface

// File: rtl/term_cmd_match.sv
// Combinational command lookup: one-hot hit vector for the buffered line, zero on a miss.
module term_cmd_match
  import term_pkg::*;
(
  input  logic [DISP_W-1:0] line,
  output logic [OP_W-1:0]   hit
);

  genvar gi;
  generate
    for (gi = 0; gi < OP_W; gi++) begin : g_cmp
      assign hit[gi] = (line == cmd_word(gi));
    end
  endgenerate

endmodule

// File: rtl/term_cmd_decoder.sv
// Line-input stage: collects keystrokes, echoes the line and decodes it on CR.
// Optional backspace editing is enabled by defining TERM_BACKSPACE_EN.
module term_cmd_decoder
  import term_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  term_cmd_decoder_if.slave bus
);

  state_t            state_reg, state_next;
  logic [7:0]        slot_reg [LINE_LEN];
  logic [2:0]        count_reg, count_next;
  logic              ovf_reg, ovf_next;
  logic              match_ok_reg, match_ok_next;
  logic [OP_W-1:0]   op_code_reg, op_code_next;
  logic [OP_W-1:0]   hit;
  logic [DISP_W-1:0] line;

  logic       accept;
  logic       printable;
  logic [7:0] key_up;
  logic       store_en;
  logic       bs_del;
  logic       clear_line;

  assign accept    = bus.key_valid && (state_reg == ST_COLLECT);
  assign printable = (bus.key_ascii >= 8'h20) && (bus.key_ascii <= 8'h7E);
  assign key_up    = ((bus.key_ascii >= 8'h61) && (bus.key_ascii <= 8'h7A)) ?
                     (bus.key_ascii - 8'h20) : bus.key_ascii;

  genvar gi;
  generate
    for (gi = 0; gi < LINE_LEN; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (reset || clear_line) begin
          slot_reg[gi] <= ASCII_SPACE;
        end else if (store_en && (count_reg == 3'(gi))) begin
          slot_reg[gi] <= key_up;
        end else if (bs_del && (count_reg == 3'(gi + 1))) begin
          slot_reg[gi] <= ASCII_SPACE;
        end
      end
      assign line[DISP_W-1-8*gi -: 8] = slot_reg[gi];
    end
  endgenerate

  term_cmd_match u_match (
    .line (line),
    .hit  (hit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_COLLECT;
      count_reg    <= '0;
      ovf_reg      <= 1'b0;
      match_ok_reg <= 1'b0;
      op_code_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      ovf_reg      <= ovf_next;
      match_ok_reg <= match_ok_next;
      op_code_reg  <= op_code_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    ovf_next      = ovf_reg;
    match_ok_next = match_ok_reg;
    op_code_next  = op_code_reg;
    store_en      = 1'b0;
    bs_del        = 1'b0;
    clear_line    = 1'b0;
    case (state_reg)
      ST_COLLECT: begin
        if (accept) begin
          if (bus.key_ascii == ASCII_CR) begin
            state_next = ST_MATCH;
          end else if (printable) begin
            if (count_reg == 3'(LINE_LEN)) begin
              ovf_next = 1'b1;
            end else begin
              store_en   = 1'b1;
              count_next = count_reg + 3'd1;
            end
          end
`ifdef TERM_BACKSPACE_EN
          else if (bus.key_ascii == ASCII_BS) begin
            // An overflowed line only loses its overflow mark; the stored five stay.
            if (ovf_reg) begin
              ovf_next = 1'b0;
            end else if (count_reg != 3'd0) begin
              bs_del     = 1'b1;
              count_next = count_reg - 3'd1;
            end
          end
`endif
        end
      end
      ST_MATCH: begin
        // An empty line is all spaces and therefore never hits the table.
        match_ok_next = (|hit) && !ovf_reg;
        if ((|hit) && !ovf_reg) begin
          op_code_next = hit;
        end
        state_next = ST_EMIT;
      end
      ST_EMIT: begin
        clear_line = 1'b1;
        count_next = '0;
        ovf_next   = 1'b0;
        state_next = ST_COLLECT;
      end
      default: begin
        state_next = ST_COLLECT;
      end
    endcase
  end

  assign bus.key_ready = (state_reg == ST_COLLECT);
  assign bus.op_strobe = (state_reg == ST_EMIT) && match_ok_reg;
  assign bus.cmd_err   = (state_reg == ST_EMIT) && !match_ok_reg;
  assign bus.op_code   = op_code_reg;
  assign bus.display   = line;

endmodule

// File: tb/tb_term_cmd_decoder.sv
// Scoreboard bench for term_cmd_decoder: a line model predicts each command outcome.
module tb_term_cmd_decoder;
  import term_pkg::*;

  logic clk;
  logic reset;
  int   cyc;
  int   n_total;
  int   n_pass;
  int   last_wait;

  term_cmd_decoder_if bus ();

  term_cmd_decoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit              err;
    logic [OP_W-1:0] op;
    int              cyc;
  } evt_t;

  evt_t sb[$];

  string cmds [OP_W] = '{"CLR", "ADD", "SUB", "MUL", "AND", "OR", "XOR", "NOT", "RXN", "LED", "HELP"};

  logic [7:0]      m_buf [LINE_LEN];
  int              m_cnt;
  bit              m_ovf;
  logic [OP_W-1:0] m_op;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [DISP_W-1:0] pad5(input string s);
    logic [DISP_W-1:0] w;
    for (int i = 0; i < LINE_LEN; i++) begin
      w[DISP_W-1-8*i -: 8] = (i < s.len()) ? s[i] : 8'h20;
    end
    return w;
  endfunction

  function automatic logic [DISP_W-1:0] m_word();
    logic [DISP_W-1:0] w;
    for (int i = 0; i < LINE_LEN; i++) w[DISP_W-1-8*i -: 8] = m_buf[i];
    return w;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < LINE_LEN; i++) m_buf[i] = 8'h20;
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  task automatic m_update(input logic [7:0] c, input bit expect_evt);
    logic [7:0]      up;
    logic [OP_W-1:0] exp_op;
    bit              hit;
    evt_t            e;
    up = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    if (c == 8'h0D) begin
      hit    = 1'b0;
      exp_op = '0;
      for (int k = 0; k < OP_W; k++) begin
        if (pad5(cmds[k]) == m_word()) begin
          hit       = 1'b1;
          exp_op[k] = 1'b1;
        end
      end
      if (expect_evt) begin
        if (hit && !m_ovf) m_op = exp_op;
        e.err = !(hit && !m_ovf);
        e.op  = m_op;
        e.cyc = cyc + 1;
        sb.push_back(e);
      end
      m_clear();
    end else if (c >= 8'h20 && c <= 8'h7E) begin
      if (m_cnt == LINE_LEN) m_ovf = 1'b1;
      else begin
        m_buf[m_cnt] = up;
        m_cnt++;
      end
    end
`ifdef TERM_BACKSPACE_EN
    else if (c == 8'h08) begin
      if (m_ovf) m_ovf = 1'b0;
      else if (m_cnt > 0) begin
        m_cnt--;
        m_buf[m_cnt] = 8'h20;
      end
    end
`endif
  endtask

  // Entered and left on a negedge; holds key_valid until the decoder takes the byte.
  task automatic send_char(input logic [7:0] c, input bit expect_evt = 1'b1);
    int waited;
    waited = 0;
    bus.key_ascii = c;
    bus.key_valid = 1'b1;
    while (!bus.key_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.key_ready) check_eq("ready_timeout", {63'd0, bus.key_ready}, 64'd1);
    @(negedge clk);
    bus.key_valid = 1'b0;
    last_wait = waited;
    m_update(c, expect_evt);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      send_char(s[i]);
      check_eq("disp_echo", bus.display, m_word());
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (bus.op_strobe || bus.cmd_err) begin
      $display("cmd event cyc=%0d strobe=%0b err=%0b op_code=%h", cyc, bus.op_strobe, bus.cmd_err, bus.op_code);
      check_eq("pulse_exclusive", {63'd0, bus.op_strobe & bus.cmd_err}, 64'd0);
      if (sb.size() == 0) begin
        check_eq("unexpected_pulse", {62'd0, bus.op_strobe, bus.cmd_err}, 64'd0);
      end else begin
        evt_t e;
        e = sb.pop_front();
        check_eq("pulse_kind", {63'd0, bus.cmd_err}, {63'd0, e.err});
        check_eq("pulse_cycle", 64'(cyc), 64'(e.cyc));
        check_eq("evt_op_code", 64'(bus.op_code), 64'(e.op));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_total       = 0;
    n_pass        = 0;
    cyc           = 0;
    last_wait     = 0;
    m_op          = '0;
    m_clear();
    reset         = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_ascii = 8'h00;
    wait_cycles(3);
    reset = 1'b0;
    @(negedge clk);

    check_eq("rst_op_code", 64'(bus.op_code), 64'd0);
    check_eq("rst_display", bus.display, 64'h2020202020);
    check_eq("rst_key_ready", {63'd0, bus.key_ready}, 64'd1);
    check_eq("rst_pulses", {62'd0, bus.op_strobe, bus.cmd_err}, 64'd0);

    send_str("rxn");
    check_eq("disp_rxn", bus.display, 64'h52584E2020);
    send_char(8'h0D);
    wait_cycles(2);
    check_eq("rxn_op_code", 64'(bus.op_code), 64'b00100000000);
    check_eq("rxn_cleared", bus.display, 64'h2020202020);

    send_str("HELLO!");
    check_eq("ovf_display", bus.display, 64'h48454C4C4F);
    send_char(8'h0D);
    wait_cycles(2);
    check_eq("ovf_op_held", 64'(bus.op_code), 64'b00100000000);

    send_str("ADX");
    send_char(8'h08);
    send_str("D");
`ifdef TERM_BACKSPACE_EN
    check_eq("bs_display", bus.display, 64'h4144442020);
`else
    check_eq("nobs_display", bus.display, 64'h4144584420);
`endif
    send_char(8'h0D);
    wait_cycles(2);
`ifdef TERM_BACKSPACE_EN
    check_eq("bs_op_code", 64'(bus.op_code), 64'b00000000010);
`else
    check_eq("nobs_op_held", 64'(bus.op_code), 64'b00100000000);
`endif

    send_str("sub");
    send_char(8'h0D);
    send_str("help");
    send_char(8'h0D);
    send_char(8'h0D);
    send_str("Or");
    send_char(8'h0D);
    send_char("A");
    check_eq("hold_wait", 64'(last_wait), 64'd2);
    check_eq("hold_display", bus.display, 64'h4120202020);
    check_eq("or_op_code", 64'(bus.op_code), 64'b00000100000);
    send_char(8'h0D);

    send_str("and");
    send_char(8'h0D, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_op = '0;
    m_clear();
    check_eq("abort_op_code", 64'(bus.op_code), 64'd0);
    check_eq("abort_display", bus.display, 64'h2020202020);
    wait_cycles(4);
    check_eq("abort_ready", {63'd0, bus.key_ready}, 64'd1);

    send_str("xor");
    send_char(8'h0D);
    wait_cycles(4);
    check_eq("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
